bilinear_calc: RTL and testbench
================================

Name: bilinear_calc

Overview:
Pipelined arithmetic back end of the bilinear scale-down path. Each cycle it may accept four neighbouring 16-bit source pixels and four 17-bit weights from the coordinate/coefficient generator. It produces one interpolated output pixel per accepted input. It sits between the frame-buffer read side and the video-out stream, and has full throughput (one result per clock).

Parameters:
- DATA_W, 16, pixel width in bits (inputs and output).
- COEF_W, 17, weight width; unsigned fixed point Q1.16, so 65536 = 1.0.
- FRAC_W, 16, number of fractional bits in the weights; the result is shifted right by this amount.

Ports:
- vin_clk, in, 1, sole clock; all logic is on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- frame_sync_n, in, 1, synchronous active-low frame restart; flushes the pipeline.
- coo_valid, in, 1, qualifies the coefficient and pixel inputs in this cycle.
- coefficient1, in, COEF_W, weight for doutbx (top-left).
- coefficient2, in, COEF_W, weight for doutbx1 (top-right).
- coefficient3, in, COEF_W, weight for doutby (bottom-left).
- coefficient4, in, COEF_W, weight for doutby1 (bottom-right).
- doutbx, in, DATA_W, pixel (x, y).
- doutbx1, in, DATA_W, pixel (x+1, y).
- doutby, in, DATA_W, pixel (x, y+1).
- doutby1, in, DATA_W, pixel (x+1, y+1).
- vout_dat, out, DATA_W, interpolated pixel.
- vout_valid, out, 1, vout_dat is valid this cycle.

Behaviour:
- Reset: while rst is high, all pipeline registers, vout_dat and vout_valid are 0. Assertion takes effect immediately (asynchronously), including mid-operation; in-flight results are discarded.
- Sampling: all inputs are captured on the same edge where coo_valid=1. Pixels arrive combinationally with the coefficients; there is no separate read latency.
- There is no back-pressure. Every accepted input produces exactly one output.
- Pipeline, fixed latency of 3 cycles: input sampled at edge N gives vout_valid=1 with its vout_dat after edge N+3.
  - S1: four products p_i = pixel_i * coefficient_i, unsigned, 33 bits each.
  - S2: two partial sums (p1+p2) and (p3+p4), 34 bits each.
  - S3: s = partial_a + partial_b (35 bits), plus the rounding term, shifted right by FRAC_W, then saturated to DATA_W. Results above 0xFFFF clamp to 0xFFFF.
- A valid bit travels alongside the data through the stages. Stage data may update freely when the valid bit is 0. vout_dat holds its last value when vout_valid=0.
- Back-to-back coo_valid produces back-to-back vout_valid, in order.
- frame_sync_n=0 at an edge clears every stage's valid bit and vout_valid. Data registers are also cleared to 0. Inputs presented with coo_valid in that same cycle are dropped.
- Weights are not normalised or checked. If the four weights do not sum to 65536, the result is simply scaled and saturation applies.
- rst has priority over frame_sync_n.

Optional Feature:
- Macro: BILINEAR_ROUND_EN.
- Defined: round half up by adding 2^(FRAC_W-1) (32768) to s before the shift.
- Undefined: truncate; there is no rounding add.
- Latency is identical in both builds.

Decomposition:
- Package bilinear_pkg holds:
  - DATA_W, COEF_W and FRAC_W defaults;
  - derived widths PROD_W=DATA_W+COEF_W and ACC_W=PROD_W+2;
  - the ROUND_HALF constant;
  - a pixel_t typedef and a coef_t typedef.
- One sub-module, bilinear_tap_mul: a registered single-tap multiplier (pixel × weight → PROD_W). It is instantiated four times for S1.
- Adders, rounding and saturation stay in bilinear_calc.

Test Plan:
- Identity weight: coefficient1=65536, others 0, all pixels 15, one coo_valid pulse → exactly one vout_valid 3 cycles later, with vout_dat=15.
- Equal weights: all coefficients 16384, pixels 0/100/200/300 → vout_dat=150. Then run 10 back-to-back inputs with distinct values and check 10 consecutive valid outputs in order.
- Rounding: coefficient1=coefficient2=32768, doutbx=1, doutbx1=2, others 0 → vout_dat=2 with BILINEAR_ROUND_EN defined, 1 without.
- Saturation: all weights 65536, all pixels 0xFFFF → vout_dat=0xFFFF. Weights summing to 65536 with all pixels 0xFFFF → 0xFFFF with no wrap.
- Flush: issue 3 consecutive inputs, then drive frame_sync_n=0 for one cycle on the edge after the last one → no vout_valid for any of them. An input issued after frame_sync_n returns high appears 3 cycles later.
- Async reset: raise rst between edges while results are in flight → vout_valid and vout_dat go to 0 immediately, and nothing emerges after release.

Source files
------------

// File: rtl/bilinear_pkg.sv
// -----------------------------------------------------------------------------
// bilinear_pkg
// Shared widths, types and helpers for the bilinear interpolation back end.
//   DATA_W     : pixel width (inputs and output)
//   COEF_W     : weight width, unsigned Q1.16 (65536 = 1.0)
//   FRAC_W     : fractional bits of the weights (final right shift)
//   PROD_W     : width of one pixel*weight product
//   ACC_W      : width of the four-product sum
//   ROUND_HALF : half an LSB of the output, added when rounding is enabled
// -----------------------------------------------------------------------------
package bilinear_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 17;
  localparam int FRAC_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 2;

  localparam logic [ACC_W-1:0] ROUND_HALF =
    {{(ACC_W - FRAC_W){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [PROD_W:0]   psum_t;
  typedef logic [ACC_W-1:0]  acc_t;

  // Clamp an already-shifted sum (one bit wider than acc_t so the rounding
  // add can never wrap) to the pixel range.
  function automatic pixel_t sat_pixel(input logic [ACC_W:0] v);
    pixel_t r;
    if (|v[ACC_W:DATA_W]) r = '1;
    else                  r = v[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/bilinear_tap_mul.sv
// -----------------------------------------------------------------------------
// bilinear_tap_mul
// Registered single-tap multiplier: prod = pix * coef, unsigned, full width.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears the product register
//   clr  : synchronous clear (frame restart), clears the product register
//   pix  : pixel operand (DATA_W)
//   coef : weight operand (COEF_W)
//   prod : registered product (PROD_W)
// -----------------------------------------------------------------------------
module bilinear_tap_mul
  import bilinear_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  pixel_t pix,
  input  coef_t  coef,
  output prod_t  prod
);

  prod_t prod_d;
  prod_t prod_q;

  always_comb begin
    prod_d = prod_t'(pix) * prod_t'(coef);
    if (clr) prod_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prod_q <= '0;
    else     prod_q <= prod_d;
  end

  assign prod = prod_q;

endmodule

// File: rtl/bilinear_calc.sv
// -----------------------------------------------------------------------------
// bilinear_calc
// Pipelined bilinear interpolation arithmetic: weighted sum of four
// neighbouring pixels, one result per clock, fixed latency of 3 cycles
// (input sampled at edge N -> vout_valid after edge N+3).
//
// Ports:
//   vin_clk          : sole clock, rising edge
//   rst              : asynchronous active-high reset
//   frame_sync_n     : synchronous active-low frame restart, flushes pipeline
//   coo_valid        : qualifies coefficient/pixel inputs this cycle
//   coefficient1..4  : Q1.16 weights for doutbx, doutbx1, doutby, doutby1
//   doutbx, doutbx1  : top-left / top-right pixels
//   doutby, doutby1  : bottom-left / bottom-right pixels
//   vout_dat         : interpolated pixel (holds when vout_valid=0)
//   vout_valid       : vout_dat valid this cycle
//
// Build option: define BILINEAR_ROUND_EN to round half up before the final
// shift; otherwise the result is truncated. Latency is the same either way.
//
// Valid semantics: there is no ready/back-pressure. A beat is transferred on
// every rising edge where coo_valid=1 (and frame_sync_n=1); each such beat
// yields exactly one vout_valid=1 cycle, in order, 3 cycles later.
//
// Stages:
//   S0 : input capture registers
//   S1 : four registered products (bilinear_tap_mul)
//   S2 : two partial sums
//   S3 : final sum, optional rounding, shift, saturation -> vout_dat
// -----------------------------------------------------------------------------
module bilinear_calc
  import bilinear_pkg::*;
(
  input  logic              vin_clk,
  input  logic              rst,
  input  logic              frame_sync_n,
  input  logic              coo_valid,
  input  logic [COEF_W-1:0] coefficient1,
  input  logic [COEF_W-1:0] coefficient2,
  input  logic [COEF_W-1:0] coefficient3,
  input  logic [COEF_W-1:0] coefficient4,
  input  logic [DATA_W-1:0] doutbx,
  input  logic [DATA_W-1:0] doutbx1,
  input  logic [DATA_W-1:0] doutby,
  input  logic [DATA_W-1:0] doutby1,
  output logic [DATA_W-1:0] vout_dat,
  output logic              vout_valid
);

  // Frame restart acts as a synchronous clear on every stage.
  logic clr;
  assign clr = ~frame_sync_n;

  // ---------------------------------------------------------------------------
  // S0: input capture
  // ---------------------------------------------------------------------------
  pixel_t pix_d  [4];
  pixel_t pix_q  [4];
  coef_t  coef_d [4];
  coef_t  coef_q [4];
  logic   v0_d;
  logic   v0_q;

  always_comb begin
    pix_d[0]  = doutbx;
    pix_d[1]  = doutbx1;
    pix_d[2]  = doutby;
    pix_d[3]  = doutby1;
    coef_d[0] = coefficient1;
    coef_d[1] = coefficient2;
    coef_d[2] = coefficient3;
    coef_d[3] = coefficient4;
    v0_d      = coo_valid;
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        pix_d[i]  = '0;
        coef_d[i] = '0;
      end
      v0_d = 1'b0;
    end
  end

  always_ff @(posedge vin_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pix_q[i]  <= '0;
        coef_q[i] <= '0;
      end
      v0_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pix_q[i]  <= pix_d[i];
        coef_q[i] <= coef_d[i];
      end
      v0_q <= v0_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: products
  // ---------------------------------------------------------------------------
  prod_t prod [4];
  logic  v1_d;
  logic  v1_q;

  for (genvar g = 0; g < 4; g++) begin : g_tap
    bilinear_tap_mul u_tap (
      .clk  (vin_clk),
      .rst  (rst),
      .clr  (clr),
      .pix  (pix_q[g]),
      .coef (coef_q[g]),
      .prod (prod[g])
    );
  end

  always_comb begin
    v1_d = v0_q;
    if (clr) v1_d = 1'b0;
  end

  always_ff @(posedge vin_clk or posedge rst) begin
    if (rst) v1_q <= 1'b0;
    else     v1_q <= v1_d;
  end

  // ---------------------------------------------------------------------------
  // S2: partial sums (top row, bottom row)
  // ---------------------------------------------------------------------------
  psum_t sum_a_d;
  psum_t sum_a_q;
  psum_t sum_b_d;
  psum_t sum_b_q;
  logic  v2_d;
  logic  v2_q;

  always_comb begin
    sum_a_d = psum_t'(prod[0]) + psum_t'(prod[1]);
    sum_b_d = psum_t'(prod[2]) + psum_t'(prod[3]);
    v2_d    = v1_q;
    if (clr) begin
      sum_a_d = '0;
      sum_b_d = '0;
      v2_d    = 1'b0;
    end
  end

  always_ff @(posedge vin_clk or posedge rst) begin
    if (rst) begin
      sum_a_q <= '0;
      sum_b_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      sum_a_q <= sum_a_d;
      sum_b_q <= sum_b_d;
      v2_q    <= v2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: final sum, rounding, shift, saturation
  // ---------------------------------------------------------------------------
  acc_t             acc_sum;
  logic [ACC_W:0]   acc_rnd;   // one spare bit so the rounding add cannot wrap
  logic [ACC_W:0]   acc_shift;
  pixel_t           vout_dat_d;
  pixel_t           vout_dat_q;
  logic             vout_valid_d;
  logic             vout_valid_q;

  always_comb begin
    acc_sum = acc_t'(sum_a_q) + acc_t'(sum_b_q);
`ifdef BILINEAR_ROUND_EN
    acc_rnd = {1'b0, acc_sum} + {1'b0, ROUND_HALF};
`else
    acc_rnd = {1'b0, acc_sum};
`endif
    acc_shift = acc_rnd >> FRAC_W;
  end

  always_comb begin
    // Output data only moves with a valid beat; otherwise it holds.
    vout_dat_d   = v2_q ? sat_pixel(acc_shift) : vout_dat_q;
    vout_valid_d = v2_q;
    if (clr) begin
      vout_dat_d   = '0;
      vout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge vin_clk or posedge rst) begin
    if (rst) begin
      vout_dat_q   <= '0;
      vout_valid_q <= 1'b0;
    end else begin
      vout_dat_q   <= vout_dat_d;
      vout_valid_q <= vout_valid_d;
    end
  end

  assign vout_dat   = vout_dat_q;
  assign vout_valid = vout_valid_q;

endmodule

// File: tb/tb_bilinear_calc.sv
// -----------------------------------------------------------------------------
// tb_bilinear_calc
// Self-checking bench for bilinear_calc. Inputs are driven and outputs
// sampled on the falling edge; expected pixels are pushed to exp_q when a beat
// is driven and popped when vout_valid is seen.
// -----------------------------------------------------------------------------
module tb_bilinear_calc;

  logic        vin_clk;
  logic        rst;
  logic        frame_sync_n;
  logic        coo_valid;
  logic [16:0] coefficient1, coefficient2, coefficient3, coefficient4;
  logic [15:0] doutbx, doutbx1, doutby, doutby1;
  logic [15:0] vout_dat;
  logic        vout_valid;

  logic [15:0] exp_q[$];
  int          pass_cnt;
  int          total_cnt;

  bilinear_calc dut (
    .vin_clk      (vin_clk),
    .rst          (rst),
    .frame_sync_n (frame_sync_n),
    .coo_valid    (coo_valid),
    .coefficient1 (coefficient1),
    .coefficient2 (coefficient2),
    .coefficient3 (coefficient3),
    .coefficient4 (coefficient4),
    .doutbx       (doutbx),
    .doutbx1      (doutbx1),
    .doutby       (doutby),
    .doutby1      (doutby1),
    .vout_dat     (vout_dat),
    .vout_valid   (vout_valid)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial vin_clk = 1'b0;
  always #5 vin_clk = ~vin_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] model(input logic [16:0] c1, c2, c3, c4,
                                        input logic [15:0] p1, p2, p3, p4);
    logic [63:0] s;
    s = 64'(p1) * 64'(c1) + 64'(p2) * 64'(c2) + 64'(p3) * 64'(c3) + 64'(p4) * 64'(c4);
`ifdef BILINEAR_ROUND_EN
    s = s + 64'd32768;
`endif
    s = s >> 16;
    return (s > 64'hFFFF) ? 16'hFFFF : s[15:0];
  endfunction

`ifdef BILINEAR_ROUND_EN
  localparam logic [15:0] ROUND_EXP = 16'd2;
`else
  localparam logic [15:0] ROUND_EXP = 16'd1;
`endif

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [16:0] c1, c2, c3, c4,
                       input logic [15:0] p1, p2, p3, p4,
                       input logic push, input logic [15:0] e);
    @(negedge vin_clk);
    coefficient1 = c1; coefficient2 = c2; coefficient3 = c3; coefficient4 = c4;
    doutbx = p1; doutbx1 = p2; doutby = p3; doutby1 = p4;
    coo_valid = 1'b1;
    if (push) exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    coo_valid = 1'b0;
    coefficient1 = '0; coefficient2 = '0; coefficient3 = '0; coefficient4 = '0;
    doutbx = '0; doutbx1 = '0; doutby = '0; doutby1 = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    frame_sync_n = 1'b1;
    idle_inputs();
    repeat (3) @(negedge vin_clk);
    total_cnt++;
    if (vout_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", vout_valid);
    else pass_cnt++;
    total_cnt++;
    if (vout_dat !== 16'h0) $display("FAIL reset_dat: got %h required 0000", vout_dat);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge vin_clk);
  endtask

  // Single-beat patterns: identity, equal weights, rounding, saturation.
  task automatic test_patterns();
    logic [16:0] tc [5][4];
    logic [15:0] tp [5][4];
    logic [15:0] te [5];
    string       nm [5];
    logic        exp_v;
    logic [15:0] e;
    nm[0] = "identity";  tc[0] = '{17'd65536, 17'd0, 17'd0, 17'd0};
    tp[0] = '{16'd15, 16'd15, 16'd15, 16'd15}; te[0] = 16'd15;
    nm[1] = "equal";     tc[1] = '{17'd16384, 17'd16384, 17'd16384, 17'd16384};
    tp[1] = '{16'd0, 16'd100, 16'd200, 16'd300}; te[1] = 16'd150;
    nm[2] = "rounding";  tc[2] = '{17'd32768, 17'd32768, 17'd0, 17'd0};
    tp[2] = '{16'd1, 16'd2, 16'd0, 16'd0}; te[2] = ROUND_EXP;
    nm[3] = "sat_over";  tc[3] = '{17'd65536, 17'd65536, 17'd65536, 17'd65536};
    tp[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; te[3] = 16'hFFFF;
    nm[4] = "sat_unity"; tc[4] = '{17'd16384, 17'd16384, 17'd16384, 17'd16384};
    tp[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; te[4] = 16'hFFFF;
    for (int t = 0; t < 5; t++) begin
      drive(tc[t][0], tc[t][1], tc[t][2], tc[t][3],
            tp[t][0], tp[t][1], tp[t][2], tp[t][3], 1'b1, te[t]);
      for (int c = 1; c <= 6; c++) begin
        @(negedge vin_clk);
        if (c == 1) idle_inputs();
        exp_v = (c == 4);
        total_cnt++;
        if (vout_valid !== exp_v)
          $display("FAIL %s_valid cycle %0d: got %b required %b", nm[t], c, vout_valid, exp_v);
        else pass_cnt++;
        if (c == 4 && vout_valid === 1'b1 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          total_cnt++;
          if (vout_dat !== e) $display("FAIL %s_dat: got %h required %h", nm[t], vout_dat, e);
          else pass_cnt++;
        end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int got;
    int first_c;
    int last_c;
    logic [15:0] e;
    got = 0; first_c = -1; last_c = -1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [16:0] c1, c2, c3, c4;
          logic [15:0] p1, p2, p3, p4;
          c1 = 17'($urandom_range(0, 131071)); c2 = 17'($urandom_range(0, 65536));
          c3 = 17'($urandom_range(0, 32768));  c4 = 17'($urandom_range(0, 16384));
          p1 = 16'($urandom_range(0, 65535)); p2 = 16'($urandom_range(0, 65535));
          p3 = 16'($urandom_range(0, 65535)); p4 = 16'(i * 1000 + 7);
          drive(c1, c2, c3, c4, p1, p2, p3, p4, 1'b1, model(c1, c2, c3, c4, p1, p2, p3, p4));
        end
        @(negedge vin_clk);
        idle_inputs();
      end
      begin
        for (int c = 0; c < 40 && got < 10; c++) begin
          @(negedge vin_clk);
          if (vout_valid === 1'b1) begin
            if (first_c < 0) first_c = c;
            last_c = c;
            total_cnt++;
            if (exp_q.size() == 0) begin
              $display("FAIL b2b_extra: got output %h required none", vout_dat);
            end else begin
              e = exp_q.pop_front();
              if (vout_dat !== e) $display("FAIL b2b_dat[%0d]: got %h required %h", got, vout_dat, e);
              else pass_cnt++;
            end
            got++;
          end
        end
      end
    join
    total_cnt++;
    if (got != 10) $display("FAIL b2b_count: got %0d outputs required 10", got);
    else pass_cnt++;
    total_cnt++;
    if (last_c - first_c != 9) $display("FAIL b2b_contiguous: got span %0d required 9", last_c - first_c);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_flush();
    logic exp_v;
    logic [15:0] e;
    drive(17'd65536, 17'd0, 17'd0, 17'd0, 16'd11, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);
    drive(17'd65536, 17'd0, 17'd0, 17'd0, 16'd22, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);
    drive(17'd65536, 17'd0, 17'd0, 17'd0, 16'd33, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);
    // Flush on the edge after the last beat; a beat offered alongside is dropped.
    drive(17'd65536, 17'd0, 17'd0, 17'd0, 16'd44, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);
    frame_sync_n = 1'b0;
    @(negedge vin_clk);
    frame_sync_n = 1'b1;
    idle_inputs();
    total_cnt++;
    if (vout_dat !== 16'h0) $display("FAIL flush_dat_clear: got %h required 0000", vout_dat);
    else pass_cnt++;
    for (int c = 0; c < 6; c++) begin
      total_cnt++;
      if (vout_valid !== 1'b0) $display("FAIL flush_valid cycle %0d: got %b required 0", c, vout_valid);
      else pass_cnt++;
      @(negedge vin_clk);
    end
    drive(17'd32768, 17'd32768, 17'd0, 17'd0, 16'd500, 16'd700, 16'd0, 16'd0, 1'b1, 16'd600);
    for (int c = 1; c <= 5; c++) begin
      @(negedge vin_clk);
      if (c == 1) idle_inputs();
      exp_v = (c == 4);
      total_cnt++;
      if (vout_valid !== exp_v) $display("FAIL post_flush_valid cycle %0d: got %b required %b", c, vout_valid, exp_v);
      else pass_cnt++;
      if (c == 4 && vout_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (vout_dat !== e) $display("FAIL post_flush_dat: got %h required %h", vout_dat, e);
        else pass_cnt++;
      end
    end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    drive(17'd65536, 17'd0, 17'd0, 17'd0, 16'h1234, 16'd0, 16'd0, 16'd0, 1'b1, 16'h1234);
    drive(17'd65536, 17'd0, 17'd0, 17'd0, 16'h4321, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);
    @(negedge vin_clk);
    idle_inputs();
    repeat (2) @(negedge vin_clk);
    total_cnt++;
    if (vout_valid !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL areset_pre_valid: got %b required 1", vout_valid);
    end else begin
      e = exp_q.pop_front();
      if (vout_dat !== e) $display("FAIL areset_pre_dat: got %h required %h", vout_dat, e);
      else pass_cnt++;
    end
    // Second beat still in flight: reset between edges.
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (vout_valid !== 1'b0) $display("FAIL areset_valid: got %b required 0", vout_valid);
    else pass_cnt++;
    total_cnt++;
    if (vout_dat !== 16'h0) $display("FAIL areset_dat: got %h required 0000", vout_dat);
    else pass_cnt++;
    @(negedge vin_clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge vin_clk);
      total_cnt++;
      if (vout_valid !== 1'b0) $display("FAIL areset_after cycle %0d: got %b required 0", c, vout_valid);
      else pass_cnt++;
    end
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_patterns();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
